// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution controller back end: default
// geometry of the result write-back stage and its FSM state type.
package cnn_pkg;

    localparam int WB_DATA_W    = 8;
    localparam int WB_PACK      = 4;
    localparam int WB_ADDR_W    = 8;
    localparam int WB_BASE_ADDR = 0;
    localparam int WB_MAX_WORDS = 43;

    typedef enum logic [1:0] {
        WB_IDLE    = 2'd0,
        WB_COLLECT = 2'd1,
        WB_WRITE   = 2'd2,
        WB_DONE    = 2'd3
    } wb_state_t;

endpackage

// File: rtl/result_writeback_if.sv
// Result stream (from the MAC array) and output-memory write port of the
// write-back stage. The stage itself uses the slave view; the environment
// (upstream producer plus memory) uses the master view.
interface result_writeback_if
    import cnn_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int PACK   = WB_PACK,
    parameter int ADDR_W = WB_ADDR_W
) ();

    logic                   res_valid;
    logic [DATA_W-1:0]      res_data;
    logic                   res_last;
    logic                   res_ready;
    logic                   mem_wr_en;
    logic [ADDR_W-1:0]      mem_addr;
    logic [PACK*DATA_W-1:0] mem_wdata;
    logic                   mem_ready;

    modport slave (
        input  res_valid, res_data, res_last, mem_ready,
        output res_ready, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output res_valid, res_data, res_last, mem_ready,
        input  res_ready, mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/result_pack_reg.sv
// PACK x DATA_W lane register. Results are loaded into successive lanes
// (lane 0 in the LSBs); clear empties every lane and rewinds the counter.
// full_o flags that the next load completes the word.
module result_pack_reg
    import cnn_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int PACK   = WB_PACK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic [DATA_W-1:0]      din_i,
    output logic [PACK*DATA_W-1:0] lanes_o,
    output logic                   full_o
);

    localparam int CNT_W = $clog2(PACK + 1);

    logic [PACK*DATA_W-1:0] lanes_q, lanes_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Next lane contents: clear wins over load; a load beyond the last lane is dropped.
    always_comb begin
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            lanes_d = {(PACK*DATA_W){1'b0}};
            cnt_d   = {CNT_W{1'b0}};
        end else if (load_i && (cnt_q < CNT_W'(PACK))) begin
            for (int i = 0; i < PACK; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    lanes_d[i*DATA_W +: DATA_W] = din_i;
                end else begin
                    lanes_d[i*DATA_W +: DATA_W] = lanes_q[i*DATA_W +: DATA_W];
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            lanes_d = lanes_q;
            cnt_d   = cnt_q;
        end
    end

    // Lane storage and fill counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes_q <= {(PACK*DATA_W){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lanes_o = lanes_q;
    assign full_o  = (cnt_q == CNT_W'(PACK - 1));

endmodule

// File: rtl/result_writeback.sv
// Result write-back stage: collects MAC results into PACK-lane words and
// writes them to consecutive output-memory addresses starting at BASE_ADDR.
// A run ends after MAX_WORDS words or after the word holding a result
// flagged last. All control outputs are registered copies of the next state.
module result_writeback
    import cnn_pkg::*;
#(
    parameter int DATA_W    = WB_DATA_W,
    parameter int PACK      = WB_PACK,
    parameter int ADDR_W    = WB_ADDR_W,
    parameter int BASE_ADDR = WB_BASE_ADDR,
    parameter int MAX_WORDS = WB_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    result_writeback_if.slave bus,
    output logic [ADDR_W-1:0] word_cnt,
    output logic              busy,
    output logic              done
);

    wb_state_t              state_q, state_d;
    logic                   last_q, last_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      word_cnt_q, word_cnt_d;
    logic                   res_ready_q, wr_en_q, busy_q, done_q;
    logic                   load_s, clr_s, full_s;
    logic [PACK*DATA_W-1:0] lanes_s;

    result_pack_reg #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_pack (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr_s),
        .load_i  (load_s),
        .din_i   (bus.res_data),
        .lanes_o (lanes_s),
        .full_o  (full_s)
    );

    // Run sequencing: collect lanes, hold the write until memory takes it, then
    // either resume collecting or finish. A write is only entered after a load,
    // so an empty word is never written.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        load_s     = 1'b0;
        clr_s      = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (start) begin
                    state_d    = WB_COLLECT;
                    addr_d     = ADDR_W'(BASE_ADDR);
                    word_cnt_d = {ADDR_W{1'b0}};
                    last_d     = 1'b0;
                    clr_s      = 1'b1;
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_COLLECT: begin
                if (bus.res_valid) begin
                    load_s = 1'b1;
                    if (full_s || bus.res_last) begin
                        state_d = WB_WRITE;
                        last_d  = bus.res_last;
                    end else begin
                        state_d = WB_COLLECT;
                    end
                end else begin
                    state_d = WB_COLLECT;
                end
            end
            WB_WRITE: begin
                if (bus.mem_ready) begin
                    addr_d     = addr_q + ADDR_W'(1);
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    last_d     = 1'b0;
                    clr_s      = 1'b1;
                    if (last_q || (word_cnt_q == ADDR_W'(MAX_WORDS - 1))) begin
                        state_d = WB_DONE;
                    end else begin
                        state_d = WB_COLLECT;
                    end
                end else begin
                    state_d = WB_WRITE;
                end
            end
            WB_DONE: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // State, address/word counters and registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WB_IDLE;
            last_q      <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            word_cnt_q  <= {ADDR_W{1'b0}};
            res_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            word_cnt_q  <= word_cnt_d;
            res_ready_q <= (state_d == WB_COLLECT);
            wr_en_q     <= (state_d == WB_WRITE);
            busy_q      <= (state_d == WB_COLLECT) || (state_d == WB_WRITE);
            done_q      <= (state_d == WB_DONE);
        end
    end

    assign bus.res_ready = res_ready_q;
    assign bus.mem_wr_en = wr_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = lanes_s;
    assign word_cnt      = word_cnt_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: random result streams are compared against a
// word-level model (results grouped PACK at a time or cut at the last flag,
// capped at MAX_WORDS words) plus directed stall and reset scenarios.
module tb_result_writeback;

    localparam int DW    = 8;
    localparam int PK    = 4;
    localparam int AW    = 8;
    localparam int BASE  = 0;
    localparam int MAXW  = 43;
    localparam int BUDGET = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] word_cnt;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] stim [0:255];

    result_writeback_if #(.DATA_W(DW), .PACK(PK), .ADDR_W(AW)) bus ();

    result_writeback #(
        .DATA_W(DW), .PACK(PK), .ADDR_W(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .word_cnt (word_cnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; start = 1'b0;
        bus.res_valid = 1'b0; bus.res_data = '0; bus.res_last = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.res_ready, bus.mem_wr_en, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b expected 0000", {bus.res_ready, bus.mem_wr_en, busy, done});
        end
        vectors++;
        if ({bus.mem_addr, word_cnt, bus.mem_wdata} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h expected 0", {bus.mem_addr, word_cnt, bus.mem_wdata});
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.res_ready, bus.mem_wr_en, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_ctrl got %b expected 0000", {bus.res_ready, bus.mem_wr_en, busy, done});
        end
    endtask

    // Generic run: stim[0..n-1] offered in order, last flag on index last_at (-1: none).
    task automatic run_stream(input string name, input int n, input int last_at,
                              input int vld_pct, input int rdy_pct, input int st_pct);
        logic [PK*DW-1:0] exp_wd[$];
        logic [PK*DW-1:0] cur;
        bit               completes [256];
        int lane, acc, idx, wr_k, cyc, expect_wr_cyc, retire_cyc;
        bit stop, done_seen;
        // model: group results into words
        cur = '0; lane = 0; acc = 0; stop = 1'b0;
        for (int i = 0; i < 256; i++) completes[i] = 1'b0;
        for (int i = 0; i < n && !stop; i++) begin
            cur[lane*DW +: DW] = stim[i];
            lane++; acc++;
            if (lane == PK || i == last_at) begin
                exp_wd.push_back(cur);
                completes[i] = 1'b1;
                cur = '0; lane = 0;
                if (i == last_at || exp_wd.size() == MAXW) stop = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b1; bus.res_valid = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx = 0; wr_k = 0; cyc = 0; expect_wr_cyc = -1; retire_cyc = -1; done_seen = 1'b0;
        while (!done_seen && cyc < BUDGET) begin
            bus.res_valid = (idx < n) && ($urandom_range(99) < vld_pct);
            bus.res_data  = bus.res_valid ? stim[idx] : DW'($urandom);
            bus.res_last  = bus.res_valid ? (idx == last_at) : 1'($urandom_range(1));
            bus.mem_ready = ($urandom_range(99) < rdy_pct);
            start         = ($urandom_range(99) < st_pct);
            if (cyc == expect_wr_cyc) begin
                vectors++;
                if (bus.mem_wr_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s wr_latency got %b expected 1", name, bus.mem_wr_en);
                end
            end
            if (retire_cyc >= 0 && cyc == retire_cyc + 1 && wr_k < exp_wd.size()) begin
                vectors++;
                if (bus.res_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s ready_after_write got %b expected 1", name, bus.res_ready);
                end
            end
            if (bus.mem_wr_en === 1'b1) begin
                vectors++;
                if (bus.res_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s ready_in_write got %b expected 0", name, bus.res_ready);
                end
                vectors++;
                if (wr_k >= exp_wd.size()) begin
                    miscompares++;
                    $display("FAIL %s extra_write got addr %h expected no write", name, bus.mem_addr);
                end else if (bus.mem_addr !== AW'(BASE + wr_k) || bus.mem_wdata !== exp_wd[wr_k]) begin
                    miscompares++;
                    $display("FAIL %s write%0d got %h/%h expected %h/%h", name, wr_k,
                             bus.mem_addr, bus.mem_wdata, AW'(BASE + wr_k), exp_wd[wr_k]);
                end
                if (bus.mem_ready) begin
                    wr_k++;
                    retire_cyc = cyc;
                end
            end
            if (done === 1'b1) begin
                done_seen = 1'b1;
                vectors++;
                if (cyc != retire_cyc + 1 || wr_k != exp_wd.size()) begin
                    miscompares++;
                    $display("FAIL %s done_timing got cyc %0d writes %0d expected cyc %0d writes %0d",
                             name, cyc, wr_k, retire_cyc + 1, exp_wd.size());
                end
            end
            if (bus.res_valid && bus.res_ready === 1'b1) begin
                if (completes[idx]) expect_wr_cyc = cyc + 1;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; bus.res_valid = 1'b1; bus.res_data = 8'hEE; bus.res_last = 1'b0;
        vectors++;
        if (!done_seen) begin
            miscompares++;
            $display("FAIL %s timeout got no done expected done within %0d cycles", name, BUDGET);
        end
        vectors++;
        if ({busy, done, bus.res_ready, bus.mem_wr_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s end_ctrl got %b expected 0000", name, {busy, done, bus.res_ready, bus.mem_wr_en});
        end
        vectors++;
        if (word_cnt !== AW'(exp_wd.size()) || bus.mem_addr !== AW'(BASE + exp_wd.size())) begin
            miscompares++;
            $display("FAIL %s end_counts got %0d/%h expected %0d/%h", name, word_cnt, bus.mem_addr,
                     exp_wd.size(), AW'(BASE + exp_wd.size()));
        end
        vectors++;
        if (idx != acc) begin
            miscompares++;
            $display("FAIL %s accepted got %0d expected %0d", name, idx, acc);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.res_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_after got %b%b expected 00", name, bus.res_ready, busy);
        end
        bus.res_valid = 1'b0;
    endtask

    task automatic test_full_word();
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44; stim[4] = 8'h55;
        run_stream("full_word", 5, 4, 100, 100, 0);
    endtask

    task automatic test_partial_last();
        stim[0] = 8'h11; stim[1] = 8'h22;
        run_stream("partial_last", 2, 1, 100, 100, 0);
    endtask

    task automatic test_mem_stall();
        logic [7:0] d [4];
        d[0] = 8'hA1; d[1] = 8'hB2; d[2] = 8'hC3; d[3] = 8'hD4;
        @(negedge clk); start = 1'b1; bus.mem_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.res_valid = 1'b1; bus.res_data = d[i]; bus.res_last = (i == 3);
            @(negedge clk);
        end
        for (int c = 0; c < 4; c++) begin
            bus.res_valid = 1'b1; bus.res_data = 8'h99; bus.res_last = 1'b0;
            bus.mem_ready = (c == 3);
            vectors++;
            if (bus.mem_wr_en !== 1'b1 || bus.res_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_ctrl%0d got wr%b rdy%b busy%b expected wr1 rdy0 busy1", c,
                         bus.mem_wr_en, bus.res_ready, busy);
            end
            vectors++;
            if (bus.mem_addr !== AW'(BASE) || bus.mem_wdata !== 32'hD4C3B2A1) begin
                miscompares++;
                $display("FAIL stall_data%0d got %h/%h expected %h/d4c3b2a1", c,
                         bus.mem_addr, bus.mem_wdata, AW'(BASE));
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        vectors++;
        if (done !== 1'b1 || bus.mem_wr_en !== 1'b0 || word_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL stall_done got done%b wr%b cnt%0d expected done1 wr0 cnt1", done, bus.mem_wr_en, word_cnt);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || bus.res_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle got done%b rdy%b busy%b expected 000", done, bus.res_ready, busy);
        end
        bus.res_valid = 1'b0;
    endtask

    task automatic test_max_words();
        for (int i = 0; i < 173; i++) stim[i] = DW'($urandom);
        run_stream("max_words", 173, -1, 100, 100, 0);
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk); start = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.res_valid = 1'b1; bus.res_data = DW'(i + 1); bus.res_last = 1'b0;
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.res_valid = 1'b1; bus.res_data = DW'(i + 5); bus.res_last = 1'b0;
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        vectors++;
        if (bus.mem_wr_en !== 1'b1 || busy !== 1'b1 || word_cnt !== 8'd1 || bus.mem_wdata !== 32'h08070605) begin
            miscompares++;
            $display("FAIL pre_reset got wr%b busy%b cnt%0d data %h expected wr1 busy1 cnt1 data 08070605",
                     bus.mem_wr_en, busy, word_cnt, bus.mem_wdata);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (bus.mem_wr_en !== 1'b0 || busy !== 1'b0 || word_cnt !== 8'd0 || bus.mem_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset got wr%b busy%b cnt%0d addr %h expected all 0",
                     bus.mem_wr_en, busy, word_cnt, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) stim[i] = DW'($urandom);
        run_stream("restart", 4, 3, 100, 100, 0);
    endtask

    task automatic test_start_in_collect();
        stim[0] = 8'h5A; stim[1] = 8'hC3; stim[2] = 8'h0F; stim[3] = 8'hF0;
        run_stream("start_ignored", 4, 3, 50, 70, 60);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(60, 10);
            for (int i = 0; i < n; i++) stim[i] = DW'($urandom);
            run_stream("random", n, $urandom_range(n - 1, 0), 70, 50, 10);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_last();
        test_mem_stall();
        test_max_words();
        test_reset_mid_write();
        test_start_in_collect();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
